fibo_req_arbiter: RTL and testbench

Round-robin scheduler that shares one `calculate_fibonacci` engine between `NUM_REQ` independent requesters. It accepts one index per transaction and screens out indices whose result overflows 16 bits. It sequences the engine's start/done handshake, guards it with a watchdog, and returns each result, tagged with the requester ID, on a shared valid/ready response channel. It sits between the request sources and the engine instance at the top level.

---
 rtl/fibo_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_fibo_req_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_req_arbiter.sv
// rtl/fibo_req_arbiter.sv - round-robin arbiter sharing one Fibonacci engine between NUM_REQ requesters
module fibo_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MAX_IDX = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*10-1:0] req_index,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_data,
    output logic                  resp_err,
    output logic                  fibo_start,
    output logic [9:0]            fibo_index,
    input  logic [15:0]           fibo_result,
    input  logic                  fibo_done,
    output logic                  eng_rst_n,
    output logic [15:0]           done_count
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last_id;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [9:0]      sel_index;
    logic [WD_W-1:0] wdog;
    logic            abort_cnt;
    logic            eng_rst_q;
    int              cand;

    // Rotating priority search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(last_id) + 1 + i) % NUM_REQ;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand);
            end
        end
    end

    assign sel_index = req_index[int'(win_id)*10 +: 10];
    assign req_ready = (state == S_IDLE && win_found && !rst)
                       ? (NUM_REQ'(1) << win_id) : '0;

    // Engine reset follows rst combinationally and is released one edge later.
    assign eng_rst_n = eng_rst_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_id    <= ID_W'(NUM_REQ - 1);
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            fibo_start <= 1'b0;
            fibo_index <= '0;
            done_count <= '0;
            wdog       <= '0;
            abort_cnt  <= 1'b0;
            eng_rst_q  <= 1'b0;
        end else begin
            fibo_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    eng_rst_q <= 1'b1;
                    if (win_found) begin
                        last_id    <= win_id;
                        resp_id    <= win_id;
                        fibo_index <= sel_index;
                        if (sel_index > 10'(MAX_IDX)) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state      <= S_RESP;
                        end else begin
                            fibo_start <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse beats a watchdog expiry in the same cycle.
                    if (fibo_done) begin
                        resp_data  <= fibo_result;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        eng_rst_q <= 1'b0;
                        abort_cnt <= 1'b0;
                        state     <= S_ABORT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_ABORT: begin
                    if (abort_cnt) begin
                        eng_rst_q  <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= '0;
                        state      <= S_RESP;
                    end else begin
                        abort_cnt <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (done_count != 16'hFFFF) begin
                            done_count <= done_count + 16'd1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_req_arbiter.sv
// tb/tb_fibo_req_arbiter.sv - directed scoreboard bench for fibo_req_arbiter with a behavioural engine
module tb_fibo_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TO      = 20;
    localparam int LAT     = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*10-1:0] req_index;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_data;
    logic                  resp_err;
    logic                  fibo_start;
    logic [9:0]            fibo_index;
    logic [15:0]           fibo_result = 16'd0;
    logic                  fibo_done = 1'b0;
    logic                  eng_rst_n;
    logic [15:0]           done_count;

    fibo_req_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .MAX_IDX(24),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fibo_start (fibo_start),
        .fibo_index (fibo_index),
        .fibo_result(fibo_result),
        .fibo_done  (fibo_done),
        .eng_rst_n  (eng_rst_n),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fib(input int n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural engine: answers LAT cycles after start unless hung.
    logic        eng_hang = 1'b0;
    logic        inj_done = 1'b0;
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic [15:0] eng_val = 16'd0;

    always @(posedge clk) begin
        if (eng_rst_n !== 1'b1) begin
            eng_busy  <= 1'b0;
            fibo_done <= 1'b0;
        end else begin
            fibo_done <= 1'b0;
            if (inj_done) begin
                fibo_done   <= 1'b1;
                fibo_result <= 16'hBEEF;
            end else if (fibo_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= LAT;
                eng_val  <= fib(int'(fibo_index));
            end else if (eng_busy && !eng_hang) begin
                if (eng_cnt == 0) begin
                    eng_busy    <= 1'b0;
                    fibo_done   <= 1'b1;
                    fibo_result <= eng_val;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    int         start_cnt = 0;
    int         eng_low = 0;
    int         idx_bad = 0;
    logic [9:0] held_idx = 10'd0;

    always @(negedge clk) begin
        if (fibo_start === 1'b1) start_cnt++;
        if (rst === 1'b0 && eng_rst_n === 1'b0) eng_low++;
        if (eng_busy && fibo_index !== held_idx) idx_bad++;
        if (fibo_start === 1'b1) held_idx = fibo_index;
    end

    typedef struct {
        int id;
        int data;
        int err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   exp_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int d, input int e);
        exp_t x;
        x.id   = id;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic do_req(input int id, input int idx, input int d, input int e);
        int n;
        req_index[id*10 +: 10] = 10'(idx);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", 64'(req_ready[id]), 64'd1);
        push_exp(id, d, e);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic get_resp(output int lat);
        int   n;
        exp_t x;
        n = 0;
        while (resp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = n + 1;
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("sb_pending", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("resp_id", 64'(resp_id), 64'(x.id));
            chk("resp_data", 64'(resp_data), 64'(x.data));
            chk("resp_err", 64'(resp_err), 64'(x.err));
        end
        if (resp_ready) begin
            @(negedge clk);
            exp_done++;
            chk("done_count", 64'(done_count), 64'(exp_done));
            chk("resp_drop", 64'(resp_valid), 64'd0);
        end
    endtask

    initial begin
        int lat;
        int n;
        int idx_tab[4];
        int res_tab[4];
        int rr_data[4];

        rst        = 1'b1;
        req_valid  = '0;
        req_index  = '0;
        resp_ready = 1'b1;

        // Reset state, with a request pending so req_ready gating is exercised.
        repeat (3) @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("reset_state", {req_ready, resp_valid, resp_id, resp_data, resp_err,
                            fibo_start, fibo_index, done_count, eng_rst_n}, 64'd0);
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("eng_rst_hold", 64'(eng_rst_n), 64'd0);
        @(negedge clk);
        chk("eng_rst_release", 64'(eng_rst_n), 64'd1);

        // Basic transaction: index 10.
        start_cnt = 0;
        do_req(0, 10, 55, 0);
        get_resp(lat);
        chk("start_pulses", 64'(start_cnt), 64'd1);

        // Edge indices with index stability tracking.
        idx_tab = '{0, 1, 2, 24};
        res_tab = '{0, 1, 1, 46368};
        idx_bad = 0;
        for (int k = 0; k < 4; k++) begin
            do_req(k, idx_tab[k], res_tab[k], 0);
            get_resp(lat);
        end
        chk("index_stable", 64'(idx_bad), 64'd0);

        // Rejected indices: error on the cycle after acceptance, no engine start.
        start_cnt = 0;
        do_req(1, 25, 0, 1);
        chk("reject_lat_25", 64'(resp_valid), 64'd1);
        get_resp(lat);
        do_req(2, 1023, 0, 1);
        chk("reject_lat_1023", 64'(resp_valid), 64'd1);
        get_resp(lat);
        chk("reject_no_start", 64'(start_cnt), 64'd0);

        // Move the rotation pointer to 3, then contend with all four requesters.
        do_req(3, 7, 13, 0);
        get_resp(lat);
        rr_data = '{2, 3, 5, 8};
        for (int i = 0; i < 4; i++) req_index[i*10 +: 10] = 10'(i + 3);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #1;
            while (req_ready === 4'b0000 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            push_exp(k % 4, rr_data[k % 4], 0);
            @(negedge clk);
            if (k == 4) req_valid = '0;
            get_resp(lat);
        end

        // Hung engine: watchdog abort, then a normal request.
        eng_hang = 1'b1;
        eng_low = 0;
        do_req(0, 9, 0, 1);
        get_resp(lat);
        chk("timeout_lat", 64'(lat), 64'(TO + 4));
        chk("abort_rst_cycles", 64'(eng_low), 64'd2);
        eng_hang = 1'b0;
        do_req(1, 12, 144, 0);
        get_resp(lat);

        // Back-pressured response with a stray done pulse and a competing requester.
        resp_ready = 1'b0;
        do_req(3, 8, 21, 0);
        req_index[19:10] = 10'd7;
        req_valid[1] = 1'b1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            inj_done = (c == 4);
            @(negedge clk);
            #1;
            chk("stall_hold", {resp_valid, resp_id, resp_data, resp_err, req_ready},
                {1'b1, 2'd3, 16'd21, 1'b0, 4'b0000});
        end
        inj_done = 1'b0;
        resp_ready = 1'b1;
        get_resp(lat);
        #1;
        chk("stall_next_grant", 64'(req_ready), 64'(4'b0010));
        push_exp(1, 13, 0);
        @(negedge clk);
        req_valid = '0;
        get_resp(lat);

        // Reset while waiting on the engine.
        do_req(0, 20, 6765, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0110;
        @(negedge clk);
        #1;
        chk("midwait_reset", {req_ready, resp_valid, resp_id, resp_data, resp_err,
                              fibo_start, fibo_index, done_count, eng_rst_n}, 64'd0);
        sb.delete();
        exp_done = 0;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("no_stale_resp", {resp_valid, fibo_done}, 64'd0);
        end
        req_index[9:0]   = 10'd15;
        req_index[19:10] = 10'd16;
        req_index[29:20] = 10'd17;
        req_valid = 4'b0111;
        #1;
        chk("post_reset_grant", 64'(req_ready), 64'(4'b0001));
        push_exp(0, 610, 0);
        @(negedge clk);
        req_valid = '0;
        get_resp(lat);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
